// File: rtl/uart_rx_readout_ctrl_pkg.sv
// Shared types and helpers for the UART RX readout path.
// Holds the read-sequencer state encoding, the default byte width and the counter-width helper.
package uart_rx_readout_ctrl_pkg;

   localparam int unsigned P_DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_LATCH = 2'd3
   } rd_state_t;

   // Bits needed to count 0..v-1, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(v)) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_readout_ctrl_if.sv
// RX FIFO read-port bundle between the readout controller and the byte FIFO.
// The controller is the master (drives the read strobe); the FIFO is the slave.
interface uart_rx_readout_ctrl_if
   import uart_rx_readout_ctrl_pkg::*;
#(
   parameter int unsigned P_DATA_W = P_DATA_W_DEF
) ();

   logic                fifo_rd_en;
   logic                fifo_empty;
   logic                fifo_full;
   logic [P_DATA_W-1:0] fifo_dout;

   modport master (
      output fifo_rd_en,
      input  fifo_empty,
      input  fifo_full,
      input  fifo_dout
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_empty,
      output fifo_full,
      output fifo_dout
   );

endinterface

// File: rtl/uart_rx_readout_ctrl_interval_tick.sv
// Free-running interval timer: one-cycle tick every P_PERIOD enabled cycles.
// Counter is held at zero while disabled, so enabling restarts the interval.
module interval_tick
   import uart_rx_readout_ctrl_pkg::*;
#(
   parameter int unsigned P_PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned          CNT_W    = clog2_min1(P_PERIOD);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(P_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_readout_ctrl.sv
// Sequences single-byte reads from the UART RX FIFO onto the two-digit hex display,
// triggered by the button edge or the auto-scan timer, and tracks RX overflow/error status.
module uart_rx_readout_ctrl
   import uart_rx_readout_ctrl_pkg::*;
#(
   parameter int unsigned P_DATA_W        = P_DATA_W_DEF,
   parameter int unsigned P_RD_LATENCY    = 1,
   parameter int unsigned P_AUTO_INTERVAL = 100000000,
   parameter int unsigned P_OVF_CNT_W     = 8
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   display_next,
   input  logic                   auto_mode,
   input  logic                   uart_valid,
   input  logic                   uart_error,
   uart_rx_readout_ctrl_if.master fifo,
   output logic [3:0]             data_msd,
   output logic [3:0]             data_lsd,
   output logic                   data_valid,
   output logic [P_OVF_CNT_W-1:0] overflow_cnt,
   output logic                   error_sticky,
   output logic                   busy
);

   localparam int unsigned      LAT_W    = clog2_min1(P_RD_LATENCY);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(P_RD_LATENCY - 1);

   rd_state_t           state;
   logic                pending;
   logic                btn_prev;
   logic                auto_tick;
   logic                req;
   logic [LAT_W-1:0]    lat_cnt;
   logic [P_DATA_W-1:0] disp_q;

   interval_tick #(
      .P_PERIOD (P_AUTO_INTERVAL)
   ) u_auto_tick (
      .clk  (CLK),
      .rst  (reset),
      .en   (auto_mode),
      .tick (auto_tick)
   );

   assign req = (display_next && !btn_prev) || auto_tick;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         pending         <= 1'b0;
         btn_prev        <= 1'b0;
         lat_cnt         <= '0;
         disp_q          <= '0;
         data_valid      <= 1'b0;
         error_sticky    <= 1'b0;
         fifo.fifo_rd_en <= 1'b0;
      end else begin
         btn_prev        <= display_next;
         fifo.fifo_rd_en <= 1'b0;

         // Clears below only fire while pending=1, so new requests are merged, never lost mid-clear.
         if (!pending && req) pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (pending) begin
                  if (!fifo.fifo_empty) begin
                     state           <= ST_REQ;
                     fifo.fifo_rd_en <= 1'b1;
                  end else begin
                     pending <= 1'b0;
                  end
               end
            end
            ST_REQ: begin
               pending <= 1'b0;
               lat_cnt <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               // Capture on leaving WAIT so the new byte is already on the outputs during LATCH.
               if (lat_cnt == LAT_LAST) begin
                  disp_q       <= fifo.fifo_dout;
                  data_valid   <= 1'b1;
                  error_sticky <= 1'b0;
                  state        <= ST_LATCH;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            ST_LATCH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (uart_error) error_sticky <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         overflow_cnt <= '0;
      end else if (uart_valid && fifo.fifo_full && !(&overflow_cnt)) begin
         overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

   assign data_msd = disp_q[7:4];
   assign data_lsd = disp_q[3:0];
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_readout_ctrl.sv
// Self-checking bench for uart_rx_readout_ctrl: bench-side FIFO plus a timeline reference model.
// Directed scenarios followed by a randomized mix; every output compared every cycle.
module tb_uart_rx_readout_ctrl;

   localparam int unsigned L    = 1;
   localparam int unsigned AUTO = 10;

   logic       CLK;
   logic       reset;
   logic       display_next;
   logic       auto_mode;
   logic       uart_valid;
   logic       uart_error;
   logic [3:0] data_msd;
   logic [3:0] data_lsd;
   logic       data_valid;
   logic [7:0] overflow_cnt;
   logic       error_sticky;
   logic       busy;

   uart_rx_readout_ctrl_if #(.P_DATA_W(8)) fifo_if ();

   uart_rx_readout_ctrl #(
      .P_DATA_W        (8),
      .P_RD_LATENCY    (L),
      .P_AUTO_INTERVAL (AUTO),
      .P_OVF_CNT_W     (8)
   ) dut (
      .CLK          (CLK),
      .reset        (reset),
      .display_next (display_next),
      .auto_mode    (auto_mode),
      .uart_valid   (uart_valid),
      .uart_error   (uart_error),
      .fifo         (fifo_if),
      .data_msd     (data_msd),
      .data_lsd     (data_lsd),
      .data_valid   (data_valid),
      .overflow_cnt (overflow_cnt),
      .error_sticky (error_sticky),
      .busy         (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int          cyc      = 0;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // Bench FIFO: popped on an observed read strobe, data presented L cycles later.
   typedef struct {
      logic [7:0] b;
      int         due;
   } stage_t;
   logic [7:0] fifo_q[$];
   stage_t     stage_q[$];

   // Reference model: a read launched at cycle R strobes at R, is busy R..R+1+L,
   // and the byte shows from R+1+L onward.
   logic [7:0] ref_q[$];
   bit         m_pending;
   int         m_read_at;
   bit         m_prev;
   int         m_auto_k;
   logic [7:0] m_disp;
   logic [7:0] m_cap;
   bit         m_valid;
   bit         m_err;
   int         m_ovf;

   bit g_btn, g_am, g_uv, g_ue, g_full, rst_cmd;

   task automatic model_reset();
      m_pending = 0;
      m_read_at = -100;
      m_prev    = 0;
      m_auto_k  = 0;
      m_disp    = 8'h00;
      m_valid   = 0;
      m_err     = 0;
      m_ovf     = 0;
   endtask

   task automatic model_step();
      bit busy_c, tick, req, clr;
      busy_c = (cyc >= m_read_at) && (cyc <= m_read_at + 1 + int'(L));
      tick   = 0;
      if (g_am) begin
         tick = ((m_auto_k + 1) % int'(AUTO)) == 0;
         m_auto_k++;
      end else begin
         m_auto_k = 0;
      end
      req    = (g_btn && !m_prev) || tick;
      m_prev = g_btn;
      clr    = 0;
      if (cyc == m_read_at + int'(L)) begin
         m_disp  = m_cap;
         m_valid = 1;
         clr     = 1;
      end
      m_err = g_ue ? 1'b1 : (clr ? 1'b0 : m_err);
      if (g_uv && g_full && m_ovf < 255) m_ovf++;
      if (m_pending) begin
         if (!busy_c) begin
            if (ref_q.size() > 0) begin
               m_read_at = cyc + 1;
               m_cap     = ref_q.pop_front();
            end else begin
               m_pending = 0;
            end
         end else if (cyc == m_read_at) begin
            m_pending = 0;
         end
      end else if (req) begin
         m_pending = 1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      ref_q.push_back(b);
   endtask

   task automatic run_cycle();
      stage_t s;
      bit     exp_busy;
      @(negedge CLK);
      if (fifo_if.fifo_rd_en && fifo_q.size() > 0) begin
         s.b   = fifo_q.pop_front();
         s.due = cyc + int'(L);
         stage_q.push_back(s);
      end
      while (stage_q.size() > 0 && stage_q[0].due <= cyc) begin
         s = stage_q.pop_front();
         fifo_if.fifo_dout = s.b;
      end
      exp_busy = (cyc >= m_read_at) && (cyc <= m_read_at + 1 + int'(L));
      check("rd_en", fifo_if.fifo_rd_en, (cyc == m_read_at) ? 1 : 0);
      check("busy", busy, exp_busy);
      check("msd", data_msd, m_disp[7:4]);
      check("lsd", data_lsd, m_disp[3:0]);
      check("data_valid", data_valid, m_valid);
      check("overflow_cnt", overflow_cnt, m_ovf);
      check("error_sticky", error_sticky, m_err);
      display_next       = g_btn;
      auto_mode          = g_am;
      uart_valid         = g_uv;
      uart_error         = g_ue;
      fifo_if.fifo_full  = g_full;
      fifo_if.fifo_empty = (fifo_q.size() == 0);
      if (rst_cmd && !reset) begin
         reset = 1'b1;
         #1;
         check("rst_rd_en", fifo_if.fifo_rd_en, 0);
         check("rst_busy", busy, 0);
         check("rst_data_valid", data_valid, 0);
         check("rst_msd_lsd", {data_msd, data_lsd}, 0);
      end
      reset = rst_cmd;
      if (reset) model_reset();
      else model_step();
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset              = 1'b1;
      display_next       = 1'b0;
      auto_mode          = 1'b0;
      uart_valid         = 1'b0;
      uart_error         = 1'b0;
      fifo_if.fifo_empty = 1'b1;
      fifo_if.fifo_full  = 1'b0;
      fifo_if.fifo_dout  = 8'h00;
      {g_btn, g_am, g_uv, g_ue, g_full} = '0;
      rst_cmd = 1'b1;
      model_reset();
      run(3);
      rst_cmd = 1'b0;
      run(2);

      // Single button read of A5.
      push(8'hA5);
      g_btn = 1; run(3);
      g_btn = 0; run(6);
      check("a5_shown", {data_msd, data_lsd}, 8'hA5);

      // Button edge with an empty FIFO: no strobe, display unchanged.
      g_btn = 1; run(2);
      g_btn = 0; run(6);

      // Auto-scan drains three bytes, then stays quiet.
      push(8'h3A); push(8'h3B); push(8'h3C);
      g_am = 1; run(50);
      g_am = 0; run(3);
      check("auto_last", {data_msd, data_lsd}, 8'h3C);

      // Overflow counter saturation.
      g_full = 1;
      for (int i = 0; i < 600; i++) begin
         g_uv = (i % 2 == 0);
         run(1);
      end
      g_uv = 0; g_full = 0; run(2);
      check("ovf_sat", overflow_cnt, 8'hFF);

      // Sticky error cleared by a latch, and held when an error coincides with it.
      g_ue = 1; run(1);
      g_ue = 0; run(2);
      push(8'h11);
      g_btn = 1; run(1);
      g_btn = 0; run(6);
      push(8'h22);
      g_btn = 1; run(1);
      g_btn = 0;
      for (int i = 0; i < 10; i++) begin
         g_ue = (cyc == m_read_at + int'(L)) || (cyc == m_read_at + int'(L) + 1);
         run(1);
      end
      g_ue = 0;
      check("err_hold", error_sticky, 1);

      // Reset while waiting on read data; the in-flight byte is lost.
      push(8'h77); push(8'h99);
      g_btn = 1; run(1);
      g_btn = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (cyc == m_read_at + 1) found = 1;
         else run(1);
      end
      check("reach_wait", found, 1);
      rst_cmd = 1; run(3);
      rst_cmd = 0; run(2);
      g_btn = 1; run(1);
      g_btn = 0; run(8);
      check("post_rst_read", {data_msd, data_lsd}, 8'h99);

      // Randomized mix of all inputs.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) g_btn = ~g_btn;
         if ($urandom_range(0, 99) == 0) g_am = ~g_am;
         g_uv    = ($urandom_range(0, 3) == 0);
         g_full  = ($urandom_range(0, 7) == 0);
         g_ue    = ($urandom_range(0, 29) == 0);
         rst_cmd = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 5) == 0 && fifo_q.size() < 16) push(8'($urandom));
         run(1);
      end
      {g_btn, g_am, g_uv, g_ue, g_full, rst_cmd} = '0;
      run(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
